// File: rtl/btn_pkg.sv
// Shared definitions for the two-channel button conditioner:
// default debounce length and the per-channel FSM state encoding.
package btn_pkg;

    // 10 ms at 100 MHz
    localparam int DEB_CYCLES_DEF = 1_000_000;

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } deb_state_t;

endpackage

// File: rtl/debounce_ch.sv
// One conditioning channel: 2-flop synchronizer, consecutive-stable debounce
// FSM with counter, and registered rise/fall pulses.
module debounce_ch
    import btn_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int CNT_W      = $clog2(DEB_CYCLES + 1)
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic x_in,
    output logic x_out,
    output logic x_rise,
    output logic x_fall
);

    logic             sync1;
    logic             sync2;
    deb_state_t       state;
    deb_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             level;
    logic             level_nxt;

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        level_nxt = level;
        case (state)
            ST_STABLE: begin
                cnt_nxt = '0;
                if (sync2 != level) begin
                    // A one-cycle debounce needs no counting phase.
                    if (DEB_CYCLES == 1) begin
                        level_nxt = sync2;
                    end else begin
                        cnt_nxt   = CNT_W'(1);
                        state_nxt = ST_PENDING;
                    end
                end
            end
            ST_PENDING: begin
                if (sync2 == level) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_STABLE;
                end else if (int'(cnt) + 1 < DEB_CYCLES) begin
                    cnt_nxt = cnt + CNT_W'(1);
                end else begin
                    level_nxt = sync2;
                    cnt_nxt   = '0;
                    state_nxt = ST_STABLE;
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = ST_STABLE;
            end
        endcase
    end

    // NOTE: non-blocking assignments here so every flop samples pre-edge values, which is what makes sync1 -> sync2 a real two-stage chain.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            state  <= ST_STABLE;
            cnt    <= '0;
            level  <= 1'b0;
            x_rise <= 1'b0;
            x_fall <= 1'b0;
        end else begin
            sync1  <= x_in;
            sync2  <= sync1;
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            level  <= level_nxt;
            // Pulses are registered alongside level so they line up with the new value.
            x_rise <= level_nxt & ~level;
            x_fall <= ~level_nxt & level;
        end
    end

    assign x_out = level;

endmodule

// File: rtl/btn_debounce2.sv
// Two independent debounced button channels feeding the downstream AND/DFF
// stage; wiring only.
module btn_debounce2
    import btn_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int CNT_W      = $clog2(DEB_CYCLES + 1)
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic A_IN,
    input  logic B_IN,
    output logic A_OUT,
    output logic B_OUT,
    output logic A_RISE,
    output logic A_FALL,
    output logic B_RISE,
    output logic B_FALL
);

    debounce_ch #(
        .DEB_CYCLES (DEB_CYCLES),
        .CNT_W      (CNT_W)
    ) u_ch_a (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .x_in   (A_IN),
        .x_out  (A_OUT),
        .x_rise (A_RISE),
        .x_fall (A_FALL)
    );

    debounce_ch #(
        .DEB_CYCLES (DEB_CYCLES),
        .CNT_W      (CNT_W)
    ) u_ch_b (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .x_in   (B_IN),
        .x_out  (B_OUT),
        .x_rise (B_RISE),
        .x_fall (B_FALL)
    );

endmodule

// File: tb/tb_btn_debounce2.sv
// Scoreboard bench for btn_debounce2: expected pulse events are queued when
// inputs are driven and matched against pulses seen on the falling edge.
module tb_btn_debounce2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic a_in  = 1'b1;
    logic b_in  = 1'b1;
    logic a_out, b_out, a_rise, a_fall, b_rise, b_fall;

    logic d1_a = 1'b0;
    logic d1_b = 1'b0;
    logic d1_a_out, d1_b_out, d1_a_rise, d1_a_fall, d1_b_rise, d1_b_fall;

    int n_checks = 0;
    int n_pass   = 0;
    int n_edges  = 0;

    typedef struct {
        int edge_n;
        int ch;
        int rise;
    } ev_t;

    ev_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) n_edges++;

    btn_debounce2 #(.DEB_CYCLES(4)) u_dut (
        .CLK    (clk),
        .RST_N  (rst_n),
        .A_IN   (a_in),
        .B_IN   (b_in),
        .A_OUT  (a_out),
        .B_OUT  (b_out),
        .A_RISE (a_rise),
        .A_FALL (a_fall),
        .B_RISE (b_rise),
        .B_FALL (b_fall)
    );

    btn_debounce2 #(.DEB_CYCLES(1)) u_dut1 (
        .CLK    (clk),
        .RST_N  (rst_n),
        .A_IN   (d1_a),
        .B_IN   (d1_b),
        .A_OUT  (d1_a_out),
        .B_OUT  (d1_b_out),
        .A_RISE (d1_a_rise),
        .A_FALL (d1_a_fall),
        .B_RISE (d1_b_rise),
        .B_FALL (d1_b_fall)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Called on a falling edge right after an input change: the change is
    // captured at the next rising edge (e0) and the pulse follows at e0 + lat.
    task automatic expect_ev(input int lat, input int ch, input int rise);
        ev_t ev;
        ev.edge_n = n_edges + 1 + lat;
        ev.ch     = ch;
        ev.rise   = rise;
        exp_q.push_back(ev);
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic scen_end(input string tag, input int ea, input int eb);
        check({tag, "_pending"}, exp_q.size(), 0);
        check({tag, "_a_out"}, int'(a_out), ea);
        check({tag, "_b_out"}, int'(b_out), eb);
    endtask

    // Channels 0/1: A/B of the DEB_CYCLES=4 DUT; 2/3: A/B of the DEB_CYCLES=1 DUT.
    always @(negedge clk) begin
        logic [3:0] rs;
        logic [3:0] fs;
        logic [3:0] lv;
        ev_t        ev;
        rs = {d1_b_rise, d1_a_rise, b_rise, a_rise};
        fs = {d1_b_fall, d1_a_fall, b_fall, a_fall};
        lv = {d1_b_out, d1_a_out, b_out, a_out};
        for (int c = 0; c < 4; c++) begin
            if (rs[c] || fs[c]) begin
                check("rise_fall_excl", int'(rs[c] & fs[c]), 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse_ch", c, -1);
                end else begin
                    ev = exp_q.pop_front();
                    check("ev_edge", n_edges, ev.edge_n);
                    check("ev_ch", c, ev.ch);
                    check("ev_kind", int'(rs[c]), ev.rise);
                    check("ev_level", int'(lv[c]), int'(rs[c]));
                end
            end
        end
    end

    initial begin
        // Reset held with both raw inputs high.
        wait_neg(3);
        check("rst_a_out", int'(a_out), 0);
        check("rst_b_out", int'(b_out), 0);
        check("rst_pulses", int'({a_rise, a_fall, b_rise, b_fall}), 0);
        rst_n = 1'b1;
        expect_ev(5, 0, 1);
        expect_ev(5, 1, 1);
        wait_neg(10);
        scen_end("reset_release", 1, 1);

        // Clean press/release on A while B sits high.
        a_in = 1'b0;
        expect_ev(5, 0, 0);
        wait_neg(10);
        scen_end("a_release", 0, 1);
        a_in = 1'b1;
        expect_ev(5, 0, 1);
        wait_neg(10);
        scen_end("a_press", 1, 1);
        a_in = 1'b0;
        expect_ev(5, 0, 0);
        wait_neg(10);
        scen_end("a_release2", 0, 1);
        b_in = 1'b0;
        expect_ev(5, 1, 0);
        wait_neg(10);
        scen_end("b_release", 0, 0);

        // Bounces with 3-cycle highs must be rejected.
        repeat (2) begin
            a_in = 1'b1;
            wait_neg(3);
            a_in = 1'b0;
            wait_neg(3);
        end
        wait_neg(6);
        scen_end("bounce", 0, 0);
        a_in = 1'b1;
        expect_ev(5, 0, 1);
        wait_neg(10);
        scen_end("bounce_settle", 1, 0);

        // Asynchronous reset in the middle of a pending count.
        a_in = 1'b0;
        expect_ev(5, 0, 0);
        wait_neg(10);
        b_in = 1'b1;
        expect_ev(5, 1, 1);
        wait_neg(10);
        scen_end("pre_async", 0, 1);
        a_in = 1'b1;
        wait_neg(2);
        #2 rst_n = 1'b0;
        #1;
        check("async_a_out", int'(a_out), 0);
        check("async_b_out", int'(b_out), 0);
        wait_neg(2);
        check("async_hold_pulses", int'({a_rise, a_fall, b_rise, b_fall}), 0);
        rst_n = 1'b1;
        expect_ev(5, 0, 1);
        expect_ev(5, 1, 1);
        wait_neg(10);
        scen_end("async_release", 1, 1);

        // Simultaneous rise, then B bounces once and restarts its count.
        a_in = 1'b0;
        b_in = 1'b0;
        expect_ev(5, 0, 0);
        expect_ev(5, 1, 0);
        wait_neg(10);
        scen_end("indep_low", 0, 0);
        a_in = 1'b1;
        b_in = 1'b1;
        expect_ev(5, 0, 1);
        wait_neg(2);
        b_in = 1'b0;
        wait_neg(1);
        b_in = 1'b1;
        expect_ev(5, 1, 1);
        wait_neg(4);
        check("indep_b_still_low", int'(b_out), 0);
        wait_neg(6);
        scen_end("indep", 1, 1);

        // DEB_CYCLES = 1 instance: output follows two edges after capture.
        d1_a = 1'b1;
        expect_ev(2, 2, 1);
        wait_neg(5);
        check("d1_a_high", int'(d1_a_out), 1);
        d1_a = 1'b0;
        expect_ev(2, 2, 0);
        wait_neg(5);
        check("d1_a_low", int'(d1_a_out), 0);
        d1_b = 1'b1;
        expect_ev(2, 3, 1);
        wait_neg(5);
        check("d1_b_high", int'(d1_b_out), 1);
        check("d1_pending", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/btn_debounce2.md
# btn_debounce2

Two-channel input conditioner that sits directly upstream of the registered AND/DFF stage. It takes two raw, asynchronous push-button/switch signals and brings each into the CLK domain with a 2-flop synchronizer. It then debounces each with a consecutive-stable counter. It drives clean levels (A_OUT, B_OUT, wired to the downstream stage's A and B) plus one-cycle rise/fall pulses for event-driven logic.

## Interface
Parameters:
- DEB_CYCLES, default 1_000_000: consecutive synchronized cycles a new value must hold before the output level changes; 10 ms at 100 MHz; legal range ≥ 1.
- CNT_W, default $clog2(DEB_CYCLES+1): counter width; derived, not overridden.

Ports:
- CLK, input, 1: system clock, all state on rising edge.
- RST_N, input, 1: one clock; reset is asynchronous and active-low. Clears all state immediately on assertion.
- A_IN, input, 1: raw asynchronous input, channel A.
- B_IN, input, 1: raw asynchronous input, channel B.
- A_OUT, output, 1: debounced level, channel A; registered.
- B_OUT, output, 1: debounced level, channel B; registered.
- A_RISE, output, 1: one-cycle pulse on A_OUT 0→1.
- A_FALL, output, 1: one-cycle pulse on A_OUT 1→0.
- B_RISE, output, 1: one-cycle pulse on B_OUT 0→1.
- B_FALL, output, 1: one-cycle pulse on B_OUT 1→0.

## Operation
- Channels are fully independent and identical. There is no cross-channel interaction.
- Synchronizer:
  - sync1 <= X_IN; sync2 <= sync1.
  - The debouncer uses only sync2 (s).
- Debounce FSM, per channel:
  - States are STABLE (cnt = 0) and PENDING (cnt > 0).
  - Registers are level (drives X_OUT) and cnt[CNT_W-1:0].
  - STABLE, s == level: stay, cnt = 0.
  - STABLE, s != level:
    - DEB_CYCLES == 1: level <= s, stay STABLE.
    - Otherwise: cnt <= 1, go to PENDING.
  - PENDING, s == level (glitch ended): cnt <= 0, go to STABLE, level unchanged.
  - PENDING, s != level, cnt+1 < DEB_CYCLES: cnt <= cnt+1.
  - PENDING, s != level, cnt+1 == DEB_CYCLES: level <= s, cnt <= 0, go to STABLE.
- Pulses:
  - X_RISE and X_FALL are registered.
  - They assert in the same cycle level first shows its new value, for exactly one cycle.
  - RISE and FALL are never high together.
- Arithmetic:
  - cnt never exceeds DEB_CYCLES-1.
  - No wrap-around is possible, because the counter clears on every level update or glitch.
- Reset:
  - All sync flops, level, cnt and pulse outputs go to 0.
  - A_OUT = B_OUT = 0 and all pulses = 0 while RST_N = 0.
- Reset mid-operation:
  - A pending count is discarded.
  - If the raw input is still high after release, a full debounce runs again and a RISE pulse is produced.

## Timing
- Let e0 be the first rising edge at which a raw change is captured in sync1.
- Level changes at edge e0 + DEB_CYCLES + 1. It is visible in the cycle after that edge, and the pulse appears in the same cycle.
  - DEB_CYCLES = 4: output changes 5 edges after e0.
- Bounces shorter than DEB_CYCLES synchronized cycles never reach X_OUT.
- Any return to the current level restarts the count from 0.
- Minimum spacing of pulses on one channel is DEB_CYCLES cycles.
- Release of RST_N is synchronous in effect: the first state update happens at the first CLK edge after deassertion.

## Structure
- Package btn_pkg holds:
  - the DEB_CYCLES default;
  - the state enum {ST_STABLE, ST_PENDING}.
- Sub-module debounce_ch contains one channel: synchronizer, FSM, counter and pulse generation. It is instantiated twice, for A and B.
- The top level is wiring only.

## Test plan
All scenarios run with DEB_CYCLES = 4.
- Reset: hold RST_N = 0 with A_IN = B_IN = 1 → all outputs 0. Release → A_OUT and B_OUT rise 5 edges later, and A_RISE and B_RISE are each high for 1 cycle.
- Clean press: A_IN 0→1 and held → A_OUT = 1 at e0 + 5 with a 1-cycle A_RISE. Then A_IN 1→0 → A_OUT = 0 five edges later with a 1-cycle A_FALL. B is unaffected throughout.
- Bounce rejection: A_IN toggles 1,0,1,0 with 3-cycle highs → A_OUT stays 0 and no pulses appear. A final stable high gives a rise at 5 edges after the last 0→1.
- Asynchronous reset mid-count: A_IN high, RST_N pulled low 2 cycles after e0 → cnt and outputs clear at once. Release with A_IN still high → full 5-edge debounce, then one A_RISE.
- Independent channels: A_IN and B_IN rise on the same edge, then B_IN bounces → A_OUT rises at e0 + 5, while B_OUT is delayed until B is stable for 4 synchronized cycles.
- DEB_CYCLES = 1 variant: an A_IN step → A_OUT follows 2 edges after e0 with a one-cycle pulse.
